// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the single-cycle MIPS core: PC register, next-PC
// selection, boot/stall handling and a saturating redirect counter.
// Optional MIPS branch delay slot is enabled with `define PC_SEQ_DELAY_SLOT_EN.
module pc_sequencer #(
    parameter int          PC_WIDTH     = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          CNT_WIDTH    = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 Stall_IN,
    input  logic                 Branch_IN,
    input  logic                 Zero_IN,
    input  logic                 Jump_IN,
    input  logic [PC_WIDTH-1:0]  Imm_IN,
    input  logic [25:0]          Jidx_IN,
    output logic [PC_WIDTH-1:0]  PC_OUT,
    output logic [PC_WIDTH-1:0]  PC_Plus4_OUT,
    output logic                 Instr_Valid_OUT,
    output logic                 Redirect_OUT,
    output logic [CNT_WIDTH-1:0] Redirect_Cnt_OUT
);

    typedef enum logic [1:0] {BOOT, RUN, SLOT} state_t;

    localparam logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(RESET_VECTOR);
    // Bits above 28 survive a jump; a 28-bit PC has no region bits at all.
    localparam logic [PC_WIDTH-1:0] REGION_MASK = {PC_WIDTH{1'b1}} << 28;

    state_t                state_q, state_next;
    logic [PC_WIDTH-1:0]   pc_q, pc_next;
    logic                  redirect_q, redirect_next;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  cnt_inc;

    logic [PC_WIDTH-1:0]   pc_plus4;
    logic [PC_WIDTH-1:0]   jump_target;
    logic [PC_WIDTH-1:0]   branch_target;
    logic [PC_WIDTH-1:0]   target;
    logic                  take;

`ifdef PC_SEQ_DELAY_SLOT_EN
    logic [PC_WIDTH-1:0]   pending_q, pending_next;
`endif

    always_comb begin
        pc_plus4      = pc_q + PC_WIDTH'(4);
        jump_target   = (pc_plus4 & REGION_MASK) | PC_WIDTH'({Jidx_IN, 2'b00});
        branch_target = pc_plus4 + (Imm_IN << 2);
        take          = Jump_IN | (Branch_IN & Zero_IN);
        target        = Jump_IN ? jump_target : branch_target;
    end

    always_comb begin
        state_next    = state_q;
        pc_next       = pc_q;
        redirect_next = 1'b0;
        cnt_inc       = 1'b0;
`ifdef PC_SEQ_DELAY_SLOT_EN
        pending_next  = pending_q;
`endif
        case (state_q)
            BOOT: state_next = RUN;
            RUN: begin
                if (!Stall_IN) begin
                    if (take) begin
`ifdef PC_SEQ_DELAY_SLOT_EN
                        // Fetch the delay-slot instruction first; the target waits.
                        pending_next = target;
                        pc_next      = pc_plus4;
                        state_next   = SLOT;
`else
                        pc_next       = target;
                        redirect_next = 1'b1;
                        cnt_inc       = 1'b1;
`endif
                    end else begin
                        pc_next = pc_plus4;
                    end
                end
            end
`ifdef PC_SEQ_DELAY_SLOT_EN
            SLOT: begin
                if (!Stall_IN) begin
                    pc_next       = pending_q;
                    redirect_next = 1'b1;
                    cnt_inc       = 1'b1;
                    state_next    = RUN;
                end
            end
`endif
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            redirect_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_next;
            pc_q       <= pc_next;
            redirect_q <= redirect_next;
            if (cnt_inc && (cnt_q != {CNT_WIDTH{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end

`ifdef PC_SEQ_DELAY_SLOT_EN
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            pending_q <= '0;
        else
            pending_q <= pending_next;
    end
`endif

    assign PC_OUT           = pc_q;
    assign PC_Plus4_OUT     = pc_plus4;
    assign Instr_Valid_OUT  = (state_q != BOOT);
    assign Redirect_OUT     = redirect_q;
    assign Redirect_Cnt_OUT = cnt_q;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter controller for the single-cycle MIPS core.
- Owns the PC register and selects the next PC each cycle: sequential (PC+4), branch target (PC+4 + sign-extended immediate shifted left twice) or jump target (region bits of PC+4 concatenated with word index shifted left twice).
- Sits between the control unit / ALU zero flag and instruction memory.
- Handles stalls and reset boot, and counts redirects for debug on the Nexys4 DDR.

Parameters:
- PC_WIDTH, 32, width of PC and address datapath (must be >= 28).
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (lower PC_WIDTH bits used; bits [1:0] must be 0).
- CNT_WIDTH, 16, width of the saturating redirect counter.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous reset, active-low.
- Stall_IN  input  1  hold PC this cycle.
- Branch_IN  input  1  current instruction is a conditional branch (beq).
- Zero_IN  input  1  ALU zero flag; branch taken when Branch_IN & Zero_IN.
- Jump_IN  input  1  current instruction is j.
- Imm_IN  input  PC_WIDTH  sign-extended 16-bit immediate.
- Jidx_IN  input  26  jump word index, instr[25:0].
- PC_OUT  output  PC_WIDTH  current fetch address.
- PC_Plus4_OUT  output  PC_WIDTH  PC_OUT + 4, combinational from the PC register.
- Instr_Valid_OUT  output  1  PC_OUT addresses a real instruction.
- Redirect_OUT  output  1  registered; high the cycle PC_OUT holds a non-sequential target.
- Redirect_Cnt_OUT  output  CNT_WIDTH  number of redirects taken, saturating.

Behaviour:
- Reset (RST=0, asynchronous):
  - PC_OUT=RESET_VECTOR, Instr_Valid_OUT=0, Redirect_OUT=0, Redirect_Cnt_OUT=0, pending target cleared, state BOOT.
  - A mid-operation reset discards any pending redirect immediately.
- States: BOOT, RUN, SLOT (SLOT exists only with the optional feature).
- BOOT:
  - First rising edge after RST deasserts moves to RUN and sets Instr_Valid_OUT=1.
  - PC is unchanged, so the first fetch is RESET_VECTOR.
  - All other inputs are ignored in BOOT.
- RUN, next-PC priority (evaluated each edge):
  - Stall_IN: PC holds, Redirect_OUT=0.
  - Jump_IN: PC <= {PC_Plus4[PC_WIDTH-1:28], Jidx_IN, 2'b00}.
  - Branch_IN & Zero_IN: PC <= PC_Plus4 + (Imm_IN << 2).
  - Otherwise: PC <= PC_Plus4.
- Arithmetic: all adds are modulo 2^PC_WIDTH; wrap-around is silent (32'hFFFF_FFFC + 4 = 0). The shift discards the top 2 bits of Imm_IN.
- Jump_IN and Branch_IN both high: Jump wins; the branch is ignored.
- Branch_IN high with Zero_IN=0: sequential PC, no redirect.
- Redirect_OUT=1 for exactly one cycle after each edge that loads a jump or taken-branch target; otherwise 0.
- Redirect_Cnt_OUT increments on each such load and saturates at all-ones.
- Stall concurrent with jump/branch: the redirect is not taken that edge. Upstream holds its inputs during the stall, so the redirect resolves on the first non-stalled edge.
- Instr_Valid_OUT stays 1 in RUN, including during stalls.

Optional Feature:
Macro: PC_SEQ_DELAY_SLOT_EN
- Defined: MIPS branch delay slot.
  - A taken redirect in RUN latches the target into a pending register and loads PC <= PC_Plus4 (delay-slot instruction); state goes to SLOT.
  - In SLOT, the next non-stalled edge loads PC <= pending target, sets Redirect_OUT=1, increments the counter and returns to RUN.
  - Jump/Branch inputs in SLOT are ignored.
  - Stall in SLOT holds both PC and the pending target.
- Undefined: SLOT state and pending register are not built; redirects take effect on the same edge as described in RUN.

Test Plan:
- Reset release with RESET_VECTOR=32'h0000_0000 -> PC_OUT=0, Instr_Valid_OUT=0 during reset; Instr_Valid_OUT=1 after the first edge; PC_OUT=0, 4, 8 on the following edges.
- PC=32'h0000_0010, Branch_IN=1, Zero_IN=1, Imm_IN=32'hFFFF_FFFC -> next PC=32'h0000_0004, Redirect_OUT=1 for one cycle, Redirect_Cnt_OUT=1; the same inputs with Zero_IN=0 -> PC=32'h0000_0014, no redirect.
- PC=32'h4000_0000, Jump_IN=1, Branch_IN=1, Zero_IN=1, Jidx_IN=26'h0000100 -> PC=32'h4000_0400 (jump wins), counter +1.
- Stall_IN=1 for 3 cycles with Jump_IN held -> PC constant for 3 cycles, Redirect_OUT=0; jump taken on the edge after Stall_IN drops.
- PC=32'hFFFF_FFFC sequential -> PC wraps to 0; force 2^CNT_WIDTH+2 redirects -> Redirect_Cnt_OUT stays at all-ones.
- With PC_SEQ_DELAY_SLOT_EN, PC=32'h100, taken branch Imm_IN=32'h4 -> PC sequence 32'h104 then 32'h114, Redirect_OUT high only with 32'h114; asserting RST during SLOT -> PC=RESET_VECTOR and no later jump to 32'h114.
